// File: rtl/pe_mux_serializer.sv
// Purpose: gathers one packed DATA_DEPTH-lane vector and emits its lanes serially, lane 0 first, each beat tagged with its lane index.
// Latency: first beat is valid the cycle after the vector is accepted; 1 lane/cycle while out_ready stays high, no bubble between back-to-back vectors.
// Backpressure: out_ready low freezes the current beat; in_ready is high in IDLE or when the last beat is transferring, and depends combinationally on out_ready.
module pe_mux_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 33,
    parameter int SEL_WIDTH  = $clog2(DATA_DEPTH),
    parameter int LEN_WIDTH  = $clog2(DATA_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_DEPTH*DATA_WIDTH-1:0] in_data,
    input  logic [LEN_WIDTH-1:0]             in_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_idx,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(DATA_DEPTH);

    state_t                 state;
    state_t                 state_n;
    logic [SEL_WIDTH-1:0]   idx;
    logic [SEL_WIDTH-1:0]   idx_n;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   eff_len;
    logic [DATA_WIDTH-1:0]  lanes [DATA_DEPTH];
    logic                   last_beat;
    logic                   accept;
    logic                   load;

    // Oversized lane counts are clamped so idx can never run past the last lane.
    assign eff_len   = (in_len > DEPTH_L) ? DEPTH_L : in_len;
    assign last_beat = (state == SEND) && (LEN_WIDTH'(idx) == (len_q - LEN_WIDTH'(1)));

    // Next-state, handshake and output decode; a new vector may be taken in the last-beat cycle to avoid a bubble.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        load      = 1'b0;
        in_ready  = (state == IDLE) || (out_ready && last_beat);
        accept    = in_valid && in_ready;
        out_valid = (state == SEND);
        busy      = (state == SEND);
        out_data  = '0;
        out_idx   = '0;
        out_last  = last_beat;

        if (state == SEND) begin
            out_data = lanes[idx];
            out_idx  = idx;
        end

        case (state)
            IDLE: begin
                // A zero-length vector is consumed here without producing a beat.
                if (accept && (eff_len != '0)) begin
                    state_n = SEND;
                    idx_n   = '0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (last_beat) begin
                        if (accept && (eff_len != '0)) begin
                            idx_n = '0;
                            load  = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n = idx + SEL_WIDTH'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and lane pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Shadow copy of the accepted vector so input changes mid-send cannot disturb the beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) begin
                lanes[i] <= '0;
            end
        end else if (load) begin
            len_q <= eff_len;
            for (int i = 0; i < DATA_DEPTH; i++) begin
                lanes[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: doc/pe_mux_serializer.md
Name: pe_mux_serializer

Overview:
- Gather-side counterpart of the PE 1-to-N demux: accepts one packed vector of DATA_DEPTH lanes (same lane layout as the demux output) and emits the lanes serially, one word per handshake, lane 0 first.
- Each beat carries its lane index, so a downstream demux can re-scatter it.
- Sits between the PE array result bus and the narrow write-back/output stream.

Parameters:
- DATA_WIDTH, 8, width of one lane word.
- DATA_DEPTH, 33, number of lanes in the packed vector.
- SEL_WIDTH, $clog2(DATA_DEPTH), width of lane index.
- LEN_WIDTH, $clog2(DATA_DEPTH+1), width of the lane-count field.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DATA_DEPTH*DATA_WIDTH  packed lanes; lane i = bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- in_len  input  LEN_WIDTH  number of lanes to emit, starting at lane 0.
- in_valid  input  1  in_data/in_len valid.
- in_ready  output  1  block can accept a vector this cycle.
- out_data  output  DATA_WIDTH  current lane word.
- out_idx  output  SEL_WIDTH  lane index of out_data.
- out_last  output  1  current beat is the final lane of the vector.
- out_valid  output  1  out_data/out_idx/out_last valid.
- out_ready  input  1  downstream accepts the beat.
- busy  output  1  high while in SEND.

Behaviour:
- Clock/reset: single clock clk; rst is synchronous, active-high, and dominates all other inputs in the same cycle.
- Reset values: state=IDLE, idx=0, shadow vector=0, len register=0. Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. in_ready=1 in the first cycle after reset.
- FSM states: IDLE, SEND.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready with eff_len>0: capture in_data into shadow register, latch eff_len, idx<=0, go to SEND.
  - eff_len = min(in_len, DATA_DEPTH); in_len>DATA_DEPTH is clamped.
  - in_len==0: vector is accepted and dropped; stay IDLE; no output beat.
- SEND:
  - out_valid=1, out_data=shadow lane[idx], out_idx=idx, out_last=(idx==len-1), busy=1.
  - Beat transfers on out_valid&&out_ready. On transfer: if out_last, go to IDLE; else idx<=idx+1.
  - Without out_ready, out_data/out_idx/out_last hold stable.
  - Changes on in_data while in SEND do not affect output (shadow copy).
- in_ready = (state==IDLE) || (state==SEND && out_ready && out_last), combinational from out_ready.
  - Accepting in the last-beat cycle loads the new vector and stays in SEND with idx=0, so there are no bubbles between vectors.
  - A zero-length vector accepted in the last-beat cycle goes to IDLE.
- Latency: first beat is valid in the cycle after input acceptance. Throughput is 1 lane/cycle with out_ready held high. A vector of L lanes occupies exactly L cycles of out_valid.
- When out_valid=0, out_data, out_idx and out_last are driven to 0.
- idx never exceeds len-1; no wrap-around past DATA_DEPTH-1.
- rst mid-vector: remaining beats are discarded, and all outputs take reset values on the next cycle.

Test Plan:
- Reset, then DATA_DEPTH=33, lanes i=i+1, in_len=33, out_ready=1 -> 33 beats on consecutive cycles; out_data=1..33, out_idx=0..32; out_last only on idx 32; busy low the cycle after.
- in_len=4, out_ready toggled 1,0,0,1,1,0,1 -> beats idx 0..3 transfer only on ready cycles; data and idx stable during stalls; out_last on idx 3; in_ready=0 until the last transfer.
- Vector A (in_len=2) and vector B (in_len=3, lanes 0xA0,0xA1,0xA2) with in_valid held high and out_ready=1 -> B accepted in A's last-beat cycle; output sequence A0,A1,0xA0,0xA1,0xA2 with no bubble.
- in_len=0 in IDLE -> in_ready=1, out_valid stays 0, busy stays 0; a following vector with in_len=1 emits exactly one beat with out_last=1.
- in_len=40 -> clamped to 33 beats; last beat idx 32.
- rst asserted after 5 beats of a 33-lane vector -> next cycle out_valid=0, out_data=0, busy=0, in_ready=1; a new vector restarts at idx 0.
